reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Tomasulo reservation station directly downstream of the labelled register file.
- Takes operand values or labels read from the register file at issue, and snoops the broadcast bus (BCEN/BClabel/BCdata) until both operands are resolved.
- Dispatches ready operations to one functional unit over a valid/ready handshake.
- Each entry owns a fixed label; the issue stage writes that label into the register file as WriteLabel.

Parameters:
- DEPTH, 4: number of entries.
- LABEL_W, 5: label width; label 0 means "no pending producer".
- DATA_W, 32: operand width.
- OP_W, 4: opcode width.
- BASE_LABEL, 1: label of entry 0; entry i owns BASE_LABEL+i. Required: BASE_LABEL>=1 and BASE_LABEL+DEPTH-1 <= 2^LABEL_W-1.

Ports:
- clk  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- issue_valid  in  1  issue request
- issue_ready  out  1  at least one free entry
- issue_op  in  OP_W  opcode
- issue_vj  in  DATA_W  operand j value, meaningful when issue_qj==0
- issue_qj  in  LABEL_W  operand j label (register file LabelOut1)
- issue_vk  in  DATA_W  operand k value
- issue_qk  in  LABEL_W  operand k label (LabelOut2)
- issue_label  out  LABEL_W  label of the entry the next issue will occupy
- BCEN  in  1  broadcast valid
- BClabel  in  LABEL_W  broadcast producer label
- BCdata  in  DATA_W  broadcast result
- fu_valid  out  1  an operation is offered to the FU
- fu_ready  in  1  FU accepts
- fu_op  out  OP_W  offered opcode
- fu_vj  out  DATA_W  offered operand j
- fu_vk  out  DATA_W  offered operand k
- fu_label  out  LABEL_W  offered entry label (FU broadcasts its result with this label)
- busy_count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (nRST==0 at a clk edge): all entries free and the hold lock is cleared.
  - Resulting outputs: busy_count=0, fu_valid=0, fu_op/fu_vj/fu_vk/fu_label=0, issue_ready=1, issue_label=BASE_LABEL.
  - Reset mid-operation discards every entry, including one currently being offered.
- Entry state: busy, op, vj, qj, vk, qk. An entry is ready when busy && qj==0 && qk==0, evaluated on registered state only.
- Issue:
  - issue_ready = any entry free at the start of the cycle.
  - issue_label = BASE_LABEL + lowest free index; when full it shows BASE_LABEL.
  - When issue_valid && issue_ready, that entry is written at the edge.
  - issue_valid while full is ignored with no state change.
- Issue bypass: if BCEN && BClabel!=0 && issue_qj==BClabel, store vj=BCdata and qj=0. The same rule applies independently to k.
- Snoop: each cycle, for every busy entry with qj!=0 && BCEN && qj==BClabel, set vj<=BCdata and qj<=0. The same rule applies to k. BClabel==0 is ignored.
- Latency: an operation is dispatchable no earlier than the cycle after its issue or after the broadcast that resolves it. Minimum issue-to-fu_valid latency is 1 cycle.
- Dispatch selection:
  - fu_valid = any ready entry.
  - The offer is the lowest-index ready entry, unless an offer is held.
  - If fu_valid && !fu_ready, the offered index is latched (hold). fu_* must stay stable until accepted, even if a lower-index entry becomes ready.
- Accept: on fu_valid && fu_ready the offered entry is freed at the edge and the hold is cleared.
- Freed-slot timing: a slot freed in cycle t is available for issue from cycle t+1. Issue and accept in the same cycle therefore never target the same slot.
- busy_count updates by +1 (issue), -1 (accept), or 0 (both or neither) each edge. It never exceeds DEPTH.
- A broadcast and an issue in the same cycle are both applied: the bypass covers the new entry and the snoop covers existing entries.

Decomposition:
- Package rs_pkg holds:
  - LABEL_NONE = 0
  - default widths
  - typedef rs_entry_t {busy, op, vj, qj, vk, qk}
- One natural sub-module, rs_entry: a single entry with load, snoop/bypass and free logic, exporting ready and its fields.
- The top level holds the free-slot and ready priority encoders and the hold register.

Test Plan:
- Reset then issue op=3, qj=0, vj=5, qk=0, vk=7:
  - issue_label=1 during the issue cycle.
  - Next cycle: fu_valid=1, fu_op=3, fu_vj=5, fu_vk=7, fu_label=1.
  - fu_ready=1 that cycle: busy_count returns to 0.
- Issue with qj=3 (vk ready), hold fu_ready=0, then broadcast BClabel=3, BCdata=10:
  - fu_valid=0 until the cycle after the broadcast.
  - Then fu_vj=10.
  - A broadcast with BClabel=4 has no effect.
- Issue qj=3 in the same cycle as BCEN=1, BClabel=3, BCdata=10: the bypass applies, and fu_valid=1 next cycle with fu_vj=10.
- Fill all 4 entries with pending qk=9:
  - issue_ready=0, busy_count=4, and a 5th issue_valid is ignored.
  - Broadcast label 9: all four become ready and dispatch in order label 1,2,3,4 with fu_ready=1.
- Hold: entry 2 is ready and offered with fu_ready=0, then entry 0 becomes ready. fu_label stays 3 until accepted; entry 0 (label 1) is offered next.
- Assert nRST=0 for one edge while fu_valid=1 with 3 entries busy: next cycle busy_count=0, fu_valid=0, issue_label=1.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants and entry record for the reservation station.
package rs_pkg;

    localparam int unsigned LABEL_NONE     = 0;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_LABEL_W    = 5;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_OP_W       = 4;
    localparam int unsigned DEF_BASE_LABEL = 1;

    typedef struct packed {
        logic                   busy;
        logic [DEF_OP_W-1:0]    op;
        logic [DEF_DATA_W-1:0]  vj;
        logic [DEF_LABEL_W-1:0] qj;
        logic [DEF_DATA_W-1:0]  vk;
        logic [DEF_LABEL_W-1:0] qk;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Issue, broadcast and functional-unit signals of the reservation station.
interface reservation_station_if #(
    parameter int unsigned DEPTH   = rs_pkg::DEF_DEPTH,
    parameter int unsigned LABEL_W = rs_pkg::DEF_LABEL_W,
    parameter int unsigned DATA_W  = rs_pkg::DEF_DATA_W,
    parameter int unsigned OP_W    = rs_pkg::DEF_OP_W
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               issue_valid;
    logic               issue_ready;
    logic [OP_W-1:0]    issue_op;
    logic [DATA_W-1:0]  issue_vj;
    logic [LABEL_W-1:0] issue_qj;
    logic [DATA_W-1:0]  issue_vk;
    logic [LABEL_W-1:0] issue_qk;
    logic [LABEL_W-1:0] issue_label;

    logic               BCEN;
    logic [LABEL_W-1:0] BClabel;
    logic [DATA_W-1:0]  BCdata;

    logic               fu_valid;
    logic               fu_ready;
    logic [OP_W-1:0]    fu_op;
    logic [DATA_W-1:0]  fu_vj;
    logic [DATA_W-1:0]  fu_vk;
    logic [LABEL_W-1:0] fu_label;

    logic [CNT_W-1:0]   busy_count;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
        output BCEN, BClabel, BCdata, fu_ready,
        input  issue_ready, issue_label, fu_valid, fu_op, fu_vj, fu_vk, fu_label,
        input  busy_count
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
        input  BCEN, BClabel, BCdata, fu_ready,
        output issue_ready, issue_label, fu_valid, fu_op, fu_vj, fu_vk, fu_label,
        output busy_count
    );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: load with issue-time bypass, broadcast snoop, free on accept.
module rs_entry
    import rs_pkg::*;
#(
    parameter int unsigned LABEL_W = DEF_LABEL_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned OP_W    = DEF_OP_W
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               i_load,
    input  logic               i_free,
    input  logic [OP_W-1:0]    i_op,
    input  logic [DATA_W-1:0]  i_vj,
    input  logic [LABEL_W-1:0] i_qj,
    input  logic [DATA_W-1:0]  i_vk,
    input  logic [LABEL_W-1:0] i_qk,
    input  logic               i_bcen,
    input  logic [LABEL_W-1:0] i_bclabel,
    input  logic [DATA_W-1:0]  i_bcdata,
    output logic               o_busy,
    output logic               o_ready,
    output logic [OP_W-1:0]    o_op,
    output logic [DATA_W-1:0]  o_vj,
    output logic [DATA_W-1:0]  o_vk
);

    logic               r_busy;
    logic [OP_W-1:0]    r_op;
    logic [DATA_W-1:0]  r_vj;
    logic [LABEL_W-1:0] r_qj;
    logic [DATA_W-1:0]  r_vk;
    logic [LABEL_W-1:0] r_qk;

    logic [LABEL_W-1:0] w_qj_src;
    logic [LABEL_W-1:0] w_qk_src;
    logic [DATA_W-1:0]  w_vj_src;
    logic [DATA_W-1:0]  w_vk_src;
    logic               w_bc_live;
    logic               w_hit_j;
    logic               w_hit_k;

    // Bypass and snoop share one match: the source is the issue bus when loading.
    assign w_qj_src  = i_load ? i_qj : r_qj;
    assign w_qk_src  = i_load ? i_qk : r_qk;
    assign w_vj_src  = i_load ? i_vj : r_vj;
    assign w_vk_src  = i_load ? i_vk : r_vk;
    assign w_bc_live = i_bcen && (i_bclabel != LABEL_W'(LABEL_NONE));
    assign w_hit_j   = w_bc_live && (w_qj_src == i_bclabel);
    assign w_hit_k   = w_bc_live && (w_qk_src == i_bclabel);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_busy <= 1'b0;
            r_op   <= '0;
            r_vj   <= '0;
            r_qj   <= '0;
            r_vk   <= '0;
            r_qk   <= '0;
        end else begin
            r_busy <= i_load || (r_busy && !i_free);
            if (i_load || r_busy) begin
                r_op <= i_load ? i_op : r_op;
                r_vj <= w_hit_j ? i_bcdata : w_vj_src;
                r_qj <= w_hit_j ? LABEL_W'(LABEL_NONE) : w_qj_src;
                r_vk <= w_hit_k ? i_bcdata : w_vk_src;
                r_qk <= w_hit_k ? LABEL_W'(LABEL_NONE) : w_qk_src;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy && (r_qj == LABEL_W'(LABEL_NONE)) && (r_qk == LABEL_W'(LABEL_NONE));
    assign o_op    = r_op;
    assign o_vj    = r_vj;
    assign o_vk    = r_vk;

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: free-slot and ready priority encoders plus the dispatch hold.
module reservation_station
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned LABEL_W    = DEF_LABEL_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned OP_W       = DEF_OP_W,
    parameter int unsigned BASE_LABEL = DEF_BASE_LABEL
) (
    input logic                  clk,
    input logic                  nRST,
    reservation_station_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]   w_busy;
    logic [DEPTH-1:0]   w_ready;
    logic [DEPTH-1:0]   w_load;
    logic [DEPTH-1:0]   w_free;
    logic [OP_W-1:0]    w_op [DEPTH];
    logic [DATA_W-1:0]  w_vj [DEPTH];
    logic [DATA_W-1:0]  w_vk [DEPTH];

    logic               w_any_free;
    logic               w_any_ready;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_ready_idx;
    logic [IDX_W-1:0]   w_sel;
    logic               w_issue;
    logic               w_accept;

    logic               r_hold;
    logic [IDX_W-1:0]   r_hold_idx;
    logic [CNT_W-1:0]   r_count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rs_entry #(
            .LABEL_W (LABEL_W),
            .DATA_W  (DATA_W),
            .OP_W    (OP_W)
        ) u_entry (
            .clk       (clk),
            .nRST      (nRST),
            .i_load    (w_load[g]),
            .i_free    (w_free[g]),
            .i_op      (bus.issue_op),
            .i_vj      (bus.issue_vj),
            .i_qj      (bus.issue_qj),
            .i_vk      (bus.issue_vk),
            .i_qk      (bus.issue_qk),
            .i_bcen    (bus.BCEN),
            .i_bclabel (bus.BClabel),
            .i_bcdata  (bus.BCdata),
            .o_busy    (w_busy[g]),
            .o_ready   (w_ready[g]),
            .o_op      (w_op[g]),
            .o_vj      (w_vj[g]),
            .o_vk      (w_vk[g])
        );
    end

    // Scanning downward leaves the lowest matching index in each encoder.
    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_any_ready = 1'b0;
        w_ready_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_any_ready = 1'b1;
                w_ready_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel    = r_hold ? r_hold_idx : w_ready_idx;
    assign w_issue  = bus.issue_valid && w_any_free;
    assign w_accept = w_any_ready && bus.fu_ready;
    assign w_load   = w_issue ? (DEPTH'(1) << w_free_idx) : '0;
    assign w_free   = w_accept ? (DEPTH'(1) << w_sel) : '0;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else if (w_accept) begin
            r_hold     <= 1'b0;
        end else if (w_any_ready) begin
            r_hold     <= 1'b1;
            r_hold_idx <= w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_count <= '0;
        end else begin
            unique case ({w_issue, w_accept})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.issue_ready = w_any_free;
    assign bus.issue_label = LABEL_W'(BASE_LABEL) + LABEL_W'(w_free_idx);
    assign bus.fu_valid    = w_any_ready;
    assign bus.fu_op       = w_any_ready ? w_op[w_sel] : '0;
    assign bus.fu_vj       = w_any_ready ? w_vj[w_sel] : '0;
    assign bus.fu_vk       = w_any_ready ? w_vk[w_sel] : '0;
    assign bus.fu_label    = w_any_ready ? LABEL_W'(BASE_LABEL) + LABEL_W'(w_sel) : '0;
    assign bus.busy_count  = r_count;

endmodule

// File: tb/tb_reservation_station.sv
// Directed and random stimulus for reservation_station against an entry-table reference model.
module tb_reservation_station;
    import rs_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LABEL_W = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned BASE    = 1;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    reservation_station_if #(
        .DEPTH(DEPTH), .LABEL_W(LABEL_W), .DATA_W(DATA_W), .OP_W(OP_W)
    ) bus ();

    reservation_station #(
        .DEPTH(DEPTH), .LABEL_W(LABEL_W), .DATA_W(DATA_W), .OP_W(OP_W), .BASE_LABEL(BASE)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    rs_entry_t m_e [DEPTH];
    bit        m_hold;
    int        m_hold_idx;

    function automatic int m_free_idx();
        for (int i = 0; i < DEPTH; i++) if (!m_e[i].busy) return i;
        return -1;
    endfunction

    function automatic int m_offer_idx();
        if (m_hold) return m_hold_idx;
        for (int i = 0; i < DEPTH; i++)
            if (m_e[i].busy && m_e[i].qj == 0 && m_e[i].qk == 0) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_e[i].busy) n++;
        return n;
    endfunction

    task automatic model_update();
        int fi, oi;
        bit acc, iss, live;
        rs_entry_t ne;
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) m_e[i] = '0;
            m_hold = 0;
            m_hold_idx = 0;
            return;
        end
        fi   = m_free_idx();
        oi   = m_offer_idx();
        acc  = (oi >= 0) && bus.fu_ready;
        iss  = bus.issue_valid && (fi >= 0);
        live = bus.BCEN && (bus.BClabel != 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_e[i].busy && live) begin
                if (m_e[i].qj == bus.BClabel) begin m_e[i].vj = bus.BCdata; m_e[i].qj = 0; end
                if (m_e[i].qk == bus.BClabel) begin m_e[i].vk = bus.BCdata; m_e[i].qk = 0; end
            end
        end
        if (acc) begin
            m_e[oi].busy = 0;
            m_hold = 0;
        end else if (oi >= 0) begin
            m_hold = 1;
            m_hold_idx = oi;
        end
        if (iss) begin
            ne.busy = 1;
            ne.op = bus.issue_op;
            ne.vj = bus.issue_vj;
            ne.qj = bus.issue_qj;
            ne.vk = bus.issue_vk;
            ne.qk = bus.issue_qk;
            if (live && ne.qj == bus.BClabel) begin ne.vj = bus.BCdata; ne.qj = 0; end
            if (live && ne.qk == bus.BClabel) begin ne.vk = bus.BCdata; ne.qk = 0; end
            m_e[fi] = ne;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int fi, oi;
        fi = m_free_idx();
        oi = m_offer_idx();
        chk("issue_ready", 32'(bus.issue_ready), 32'(fi >= 0));
        chk("issue_label", 32'(bus.issue_label), (fi >= 0) ? 32'(BASE + fi) : 32'(BASE));
        chk("fu_valid", 32'(bus.fu_valid), 32'(oi >= 0));
        chk("fu_op", 32'(bus.fu_op), (oi >= 0) ? 32'(m_e[oi].op) : 32'd0);
        chk("fu_vj", bus.fu_vj, (oi >= 0) ? m_e[oi].vj : 32'd0);
        chk("fu_vk", bus.fu_vk, (oi >= 0) ? m_e[oi].vk : 32'd0);
        chk("fu_label", 32'(bus.fu_label), (oi >= 0) ? 32'(BASE + oi) : 32'd0);
        chk("busy_count", 32'(bus.busy_count), 32'(m_count()));
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 0;
        bus.issue_op = '0;
        bus.issue_vj = '0;
        bus.issue_qj = '0;
        bus.issue_vk = '0;
        bus.issue_qk = '0;
        bus.BCEN = 0;
        bus.BClabel = '0;
        bus.BCdata = '0;
        bus.fu_ready = 0;
    endtask

    task automatic issue(input int op, input int vj, input int qj, input int vk, input int qk);
        bus.issue_valid = 1;
        bus.issue_op = OP_W'(op);
        bus.issue_vj = DATA_W'(vj);
        bus.issue_qj = LABEL_W'(qj);
        bus.issue_vk = DATA_W'(vk);
        bus.issue_qk = LABEL_W'(qk);
    endtask

    task automatic bcast(input int lbl, input int data);
        bus.BCEN = 1;
        bus.BClabel = LABEL_W'(lbl);
        bus.BCdata = DATA_W'(data);
    endtask

    initial begin
        idle();
        nRST = 0;
        @(posedge clk);
        model_update();
        #1;
        tick();
        chk("rst_busy_count", 32'(bus.busy_count), 32'd0);
        chk("rst_issue_label", 32'(bus.issue_label), 32'd1);
        chk("rst_fu_valid", 32'(bus.fu_valid), 32'd0);
        nRST = 1;

        // Ready issue dispatches one cycle later.
        idle(); issue(3, 5, 0, 7, 0);
        chk("t1_issue_label", 32'(bus.issue_label), 32'd1);
        tick();
        idle(); bus.fu_ready = 1;
        chk("t1_fu_valid", 32'(bus.fu_valid), 32'd1);
        chk("t1_fu_op", 32'(bus.fu_op), 32'd3);
        chk("t1_fu_vj", bus.fu_vj, 32'd5);
        chk("t1_fu_vk", bus.fu_vk, 32'd7);
        chk("t1_fu_label", 32'(bus.fu_label), 32'd1);
        tick();
        idle();
        chk("t1_busy_count", 32'(bus.busy_count), 32'd0);

        // Pending qj resolved by a later broadcast; foreign label ignored.
        issue(1, 0, 3, 8, 0); tick();
        idle(); tick();
        chk("t2_wait", 32'(bus.fu_valid), 32'd0);
        bcast(4, 99); tick();
        idle();
        chk("t2_other_label", 32'(bus.fu_valid), 32'd0);
        bcast(3, 10); tick();
        idle();
        chk("t2_resolved", 32'(bus.fu_valid), 32'd1);
        chk("t2_fu_vj", bus.fu_vj, 32'd10);
        bus.fu_ready = 1; tick();

        // Same-cycle bypass at issue.
        idle(); issue(2, 0, 3, 8, 0); bcast(3, 10); tick();
        idle();
        chk("t3_valid", 32'(bus.fu_valid), 32'd1);
        chk("t3_fu_vj", bus.fu_vj, 32'd10);
        bus.fu_ready = 1; tick();

        // Fill, overflow attempt, broadcast release, in-order drain.
        for (int i = 0; i < 4; i++) begin
            idle(); issue(i + 4, i, 0, 0, 9); tick();
        end
        idle();
        chk("t4_full_ready", 32'(bus.issue_ready), 32'd0);
        chk("t4_full_count", 32'(bus.busy_count), 32'd4);
        issue(15, 1, 0, 1, 0); tick();
        idle();
        chk("t4_ignored", 32'(bus.busy_count), 32'd4);
        bcast(9, 77); tick();
        for (int i = 0; i < 4; i++) begin
            idle(); bus.fu_ready = 1;
            chk("t4_order", 32'(bus.fu_label), 32'(i + 1));
            tick();
        end

        // Hold keeps label 3 offered although label 1 becomes ready.
        idle(); issue(1, 0, 5, 0, 0); tick();
        idle(); issue(2, 0, 6, 0, 0); tick();
        idle(); issue(3, 11, 0, 12, 0); tick();
        idle(); tick();
        chk("t5_offer", 32'(bus.fu_label), 32'd3);
        bcast(5, 55); tick();
        idle(); tick();
        chk("t5_held", 32'(bus.fu_label), 32'd3);
        bus.fu_ready = 1; tick();
        idle();
        chk("t5_next", 32'(bus.fu_label), 32'd1);
        bus.fu_ready = 1; tick();
        idle(); bcast(6, 66); tick();
        idle(); bus.fu_ready = 1; tick();

        // Reset while an offer is live.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(i, i, 0, i, 0); tick();
        end
        idle();
        chk("t6_pre_valid", 32'(bus.fu_valid), 32'd1);
        chk("t6_pre_count", 32'(bus.busy_count), 32'd3);
        nRST = 0; tick();
        nRST = 1;
        chk("t6_count", 32'(bus.busy_count), 32'd0);
        chk("t6_valid", 32'(bus.fu_valid), 32'd0);
        chk("t6_label", 32'(bus.issue_label), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            nRST = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 1) == 1)
                issue($urandom_range(0, 15), $urandom, $urandom_range(0, 1) ? 0 : $urandom_range(1, 7),
                      $urandom, $urandom_range(0, 1) ? 0 : $urandom_range(1, 7));
            if ($urandom_range(0, 2) == 0) bcast($urandom_range(0, 7), $urandom);
            bus.fu_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        nRST = 1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
